// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Responder side of the CPU data-memory bus. Captures one load/store request
//   per transaction, waits WAIT_STATES extra cycles, then performs the access
//   and signals completion with a one-cycle ready pulse (plus error for an
//   out-of-range address). Owns the storage array.
//
//   Optional feature, enabled by defining the macro DMEM_OUTPORT_EN:
//   a memory-mapped output register at OUT_ADDR drives out_port. Without the
//   macro out_port is tied to 0 and OUT_ADDR decodes like any other address.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   cs             request valid, held by the requester until ready
//   read_not_write 1 = load, 0 = store
//   address        word address
//   write_data     store data
//   read_data      registered load data, held until the next completed load
//   ready          one-cycle completion pulse
//   error          one-cycle pulse alongside ready for an out-of-range access
//   out_port       memory-mapped output register (0 when the feature is off)
//
// Timing: with the request captured at edge N, the access is performed and
// ready is raised at edge N+WAIT_STATES+1 (the edge leaving RESP). That cycle
// is spent in IDLE, so a cs still high there starts the next request.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned            DATA_WIDTH  = 24,
  parameter int unsigned            ADDR_WIDTH  = 11,
  parameter int unsigned            DEPTH       = 1024,
  parameter int unsigned            WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0]  OUT_ADDR    = ADDR_WIDTH'(11'h7FF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read_not_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  // Counter start value; unused when there are no wait states.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      cnt_nxt;

  // Latched request
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_rnw;

  // Decode / control
  logic                  capture;
  logic                  fire;
  logic                  in_range;
  logic                  hit_out;
  logic                  hit_mem;
  logic                  mem_we;
  logic                  out_we;
  logic                  err_nxt;
  logic [IDX_W-1:0]      mem_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] out_q;

`ifdef DMEM_OUTPORT_EN
  localparam bit OUT_EN = 1'b1;

  // Memory-mapped output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (out_we) begin
      out_q <= req_data;
    end
  end

  assign out_port = out_q;
`else
  localparam bit OUT_EN = 1'b0;

  assign out_q    = '0;
  assign out_port = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cs) begin
          state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    capture  = 1'b0;
    fire     = 1'b0;
    cnt_nxt  = wait_cnt;
    in_range = 1'b0;
    hit_out  = 1'b0;
    hit_mem  = 1'b0;
    mem_we   = 1'b0;
    out_we   = 1'b0;
    err_nxt  = 1'b0;
    mem_idx  = IDX_W'(req_addr);

    capture  = (state == IDLE) && cs;
    fire     = (state == RESP);

    if (capture) begin
      cnt_nxt = CNT_INIT;
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      cnt_nxt = wait_cnt - CNT_W'(1);
    end

    // Output register wins over the storage/range decode.
    in_range = (32'(req_addr) < DEPTH);
    hit_out  = OUT_EN && (req_addr == OUT_ADDR);
    hit_mem  = !hit_out && in_range;

    mem_we   = fire && !req_rnw && hit_mem;
    out_we   = fire && !req_rnw && hit_out;
    err_nxt  = fire && !hit_out && !in_range;
  end

  // Wait counter, request latch and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      req_addr  <= '0;
      req_data  <= '0;
      req_rnw   <= 1'b0;
      read_data <= '0;
      ready     <= 1'b0;
      error     <= 1'b0;
    end else begin
      wait_cnt <= cnt_nxt;
      ready    <= fire;
      error    <= err_nxt;
      if (capture) begin
        req_addr <= address;
        req_data <= write_data;
        req_rnw  <= read_not_write;
      end
      if (fire && req_rnw) begin
        if (hit_out) begin
          read_data <= out_q;
        end else if (hit_mem) begin
          read_data <= mem[mem_idx];
        end else begin
          read_data <= '0;
        end
      end
    end
  end

  // Storage write port; not cleared by reset, and a reset on the access
  // edge discards the store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_idx] <= req_data;
    end
  end

endmodule
